// File: rtl/dispatch_steer.sv
// Dispatch stage: in-order packet FIFO that steers its head to the ALU/LSU/BRU issue ports,
// with branch-in-flight throttling and flush. Optional stall counter under DISPATCH_STATS_EN.
package dispatch_pkg;
  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_LSU = 2'd1;
  localparam logic [1:0] FU_BRU = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  fu_type;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } decode_pkt_t;
endpackage

module dispatch_steer
  import dispatch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MAX_BR = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_out,
  input  decode_pkt_t pkt_in,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic        lsu_valid,
  input  logic        lsu_ready,
  output logic        bru_valid,
  input  logic        bru_ready,
  output decode_pkt_t pkt_out,
  input  logic        br_resolve,
  input  logic        flush,
  output logic [3:0]  br_inflight
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);

  decode_pkt_t     mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW:0]     count_r;
  logic [3:0]      br_cnt_r;

  decode_pkt_t     head_s;
  logic            empty_s;
  logic            head_bru_s;
  logic            head_lsu_s;
  logic            eligible_s;
  logic            offer_s;
  logic            pop_s;
  logic            bru_pop_s;
  logic            push_s;
  logic            resolve_s;

  // Head decode, steering and handshake qualification; valids never look at the readies.
  always_comb begin
    head_s      = mem_r[rd_ptr_r];
    empty_s     = (count_r == '0);
    head_bru_s  = (head_s.fu_type == FU_BRU);
    head_lsu_s  = (head_s.fu_type == FU_LSU);
    eligible_s  = !(head_bru_s && (br_cnt_r == 4'(MAX_BR)));
    offer_s     = !empty_s && eligible_s && !flush && !rst;
    alu_valid   = offer_s && !head_bru_s && !head_lsu_s;
    lsu_valid   = offer_s && head_lsu_s;
    bru_valid   = offer_s && head_bru_s;
    bru_pop_s   = bru_valid && bru_ready;
    pop_s       = (alu_valid && alu_ready) || (lsu_valid && lsu_ready) || bru_pop_s;
    ready_out   = !rst && (count_r != (AW+1)'(DEPTH));
    push_s      = valid_in && ready_out && !flush;
    // A resolve with nothing in flight is spurious and must not underflow the counter.
    resolve_s   = br_resolve && (br_cnt_r != 4'd0);
    pkt_out     = rst ? decode_pkt_t'('0) : head_s;
    br_inflight = br_cnt_r;
  end

  // FIFO storage, pointers, occupancy and branch counter; flush wins over everything but rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      br_cnt_r <= 4'd0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      br_cnt_r <= 4'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pkt_in;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      case ({bru_pop_s, resolve_s})
        2'b10:   br_cnt_r <= br_cnt_r + 4'd1;
        2'b01:   br_cnt_r <= br_cnt_r - 4'd1;
        default: br_cnt_r <= br_cnt_r;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  // Saturating count of occupied-but-not-popping cycles; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (!flush && !empty_s && !pop_s && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_steer.sv
// Directed bench for dispatch_steer: a queue scoreboard predicts each dispatched packet,
// its port, ready_out and the branch counter from the stimulus alone.
module tb_dispatch_steer;
  import dispatch_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MAX_BR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  decode_pkt_t pkt_in = '0;
  logic        alu_valid, lsu_valid, bru_valid;
  logic        alu_ready = 1'b0, lsu_ready = 1'b0, bru_ready = 1'b0;
  decode_pkt_t pkt_out;
  logic        br_resolve = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  br_inflight;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_cycles;
`endif

  dispatch_steer #(.DEPTH(DEPTH), .MAX_BR(MAX_BR)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .pkt_in(pkt_in),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .bru_valid(bru_valid), .bru_ready(bru_ready), .pkt_out(pkt_out),
    .br_resolve(br_resolve), .flush(flush), .br_inflight(br_inflight)
`ifdef DISPATCH_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  decode_pkt_t sb_q[$];
  int          br_m = 0;
  logic [31:0] stall_m = 32'd0;
  logic [31:0] s0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic decode_pkt_t mk(input logic [31:0] pc, input logic [1:0] fu);
    decode_pkt_t p;
    p.pc      = pc;
    p.fu_type = fu;
    p.rd      = pc[4:0];
    p.opcode  = pc[6:0];
    return p;
  endfunction

  task automatic rst_cyc();
    rst = 1'b1; valid_in = 1'b1; pkt_in = mk(32'hFFFF_0000, FU_BRU);
    alu_ready = 1'b1; lsu_ready = 1'b1; bru_ready = 1'b1; br_resolve = 1'b1; flush = 1'b0;
    #1;
    chk("rst_ready", {63'd0, ready_out}, 64'd0);
    chk("rst_valids", {61'd0, alu_valid, lsu_valid, bru_valid}, 64'd0);
    chk("rst_pkt", 64'(pkt_out), 64'd0);
    @(posedge clk);
    sb_q.delete(); br_m = 0; stall_m = 32'd0;
    @(negedge clk);
    chk("rst_br", {60'd0, br_inflight}, 64'd0);
  endtask

  // One clock: drive at negedge, check the scoreboard prediction, then advance the model.
  task automatic cyc(input logic vin, input decode_pkt_t p, input logic ar, input logic lr,
                     input logic brr, input logic res, input logic fl);
    int n;
    logic e_rdy, e_alu, e_lsu, e_bru, elig, pop, bpop, reff;
    valid_in = vin; pkt_in = p; alu_ready = ar; lsu_ready = lr; bru_ready = brr;
    br_resolve = res; flush = fl;
    #1;
    n     = sb_q.size();
    e_rdy = (n != DEPTH);
    e_alu = 1'b0; e_lsu = 1'b0; e_bru = 1'b0;
    if (n > 0 && !fl) begin
      elig  = !(sb_q[0].fu_type == FU_BRU && br_m == MAX_BR);
      e_bru = elig && (sb_q[0].fu_type == FU_BRU);
      e_lsu = elig && (sb_q[0].fu_type == FU_LSU);
      e_alu = elig && !e_bru && !e_lsu && (sb_q[0].fu_type != FU_BRU);
    end
    chk("ready_out", {63'd0, ready_out}, {63'd0, e_rdy});
    chk("alu_valid", {63'd0, alu_valid}, {63'd0, e_alu});
    chk("lsu_valid", {63'd0, lsu_valid}, {63'd0, e_lsu});
    chk("bru_valid", {63'd0, bru_valid}, {63'd0, e_bru});
    chk("br_inflight", {60'd0, br_inflight}, 64'(br_m));
    if (n > 0) chk("pkt_out", 64'(pkt_out), 64'(sb_q[0]));
`ifdef DISPATCH_STATS_EN
    chk("stall_cycles", {32'd0, stall_cycles}, {32'd0, stall_m});
`endif
    @(posedge clk);
    if (fl) begin
      sb_q.delete(); br_m = 0;
    end else begin
      pop  = (e_alu && ar) || (e_lsu && lr) || (e_bru && brr);
      bpop = e_bru && brr;
      reff = res && (br_m != 0);
      br_m = br_m + (bpop ? 1 : 0) - (reff ? 1 : 0);
      if (n > 0 && !pop && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      if (pop) void'(sb_q.pop_front());
      if (vin && e_rdy) sb_q.push_back(p);
    end
    @(negedge clk);
  endtask

  initial begin
    decode_pkt_t z;
    z = '0;
    @(negedge clk);
    rst_cyc();
    rst_cyc();
    rst = 1'b0;

    // Single ALU packet, then an all-zero NOP and an unknown fu_type, all to ALU.
    cyc(1'b1, mk(32'h100, FU_ALU), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_alu_valid", {63'd0, alu_valid}, 64'd1);
    chk("t1_pc", {32'd0, pkt_out.pc}, 64'h100);
    cyc(1'b0, z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(32'h104, 2'd3), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill with all readies low, overflow attempt, then one LSU pop.
    cyc(1'b1, mk(32'h200, FU_LSU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(32'h204, FU_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(32'h208, FU_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(32'h20C, FU_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_full", {63'd0, ready_out}, 64'd0);
    cyc(1'b1, mk(32'h210, FU_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_ready_back", {63'd0, ready_out}, 64'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch throttle at MAX_BR.
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(32'h300 + 32'(4 * i), FU_BRU), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, mk(32'h400, FU_ALU), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, z, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_br4", {60'd0, br_inflight}, 64'd4);
    chk("t3_throttled", {63'd0, bru_valid}, 64'd0);
    cyc(1'b0, z, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_bru_after_resolve", {63'd0, bru_valid}, 64'd1);
    cyc(1'b0, z, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_br_stays4", {60'd0, br_inflight}, 64'd4);
    cyc(1'b0, z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Coincident pop/resolve, and resolve at zero.
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, mk(32'h500, FU_BRU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, z, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_br_stays2", {60'd0, br_inflight}, 64'd2);
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_no_underflow", {60'd0, br_inflight}, 64'd0);

    // Flush with 3 queued packets, 3 branches in flight and a valid_in in the same cycle.
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'h580 + 32'(4 * i), FU_BRU), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'h600 + 32'(4 * i), FU_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_br3", {60'd0, br_inflight}, 64'd3);
    cyc(1'b1, mk(32'hDEAD, FU_ALU), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_br0", {60'd0, br_inflight}, 64'd0);
    chk("t5_ready", {63'd0, ready_out}, 64'd1);
    chk("t5_valids", {61'd0, alu_valid, lsu_valid, bru_valid}, 64'd0);
    cyc(1'b0, z, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, z, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // LSU head stalled 7 cycles, then flushed.
    s0 = stall_m;
    cyc(1'b1, mk(32'h700, FU_LSU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DISPATCH_STATS_EN
    chk("t6_stall7", {32'd0, stall_cycles}, {32'd0, s0 + 32'd7});
`endif
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef DISPATCH_STATS_EN
    chk("t6_stall_kept", {32'd0, stall_cycles}, {32'd0, s0 + 32'd7});
`endif
    cyc(1'b0, z, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_steer.md
Name: dispatch_steer

Overview:
- Sequential stage between decode and the per-FU issue queues.
- Buffers decoded packets in a small in-order FIFO and steers the head packet to the ALU, LSU or BRU port by its fu_type.
- Throttles in-flight control-flow ops with a branch counter, and clears all state on pipeline flush.
- Decouples decode's combinational ready passthrough from downstream backpressure: ready_out depends only on registered state.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_BR, 4, maximum dispatched-but-unresolved BRU ops (branch or jump); range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  decoded packet valid
- ready_out  out  1  FIFO can accept
- pkt_in  in  decode_pkt_t  decoded packet
- alu_valid  out  1  head packet offered to ALU queue
- alu_ready  in  1  ALU queue accepts
- lsu_valid  out  1  head offered to LSU queue
- lsu_ready  in  1  LSU queue accepts
- bru_valid  out  1  head offered to BRU queue
- bru_ready  in  1  BRU queue accepts
- pkt_out  out  decode_pkt_t  head packet, shared by all three ports
- br_resolve  in  1  one BRU op resolved this cycle
- flush  in  1  squash everything not yet dispatched
- br_inflight  out  4  current branch counter

Behaviour:
- Reset: one clock, synchronous, active-high.
  - While rst=1: FIFO empty, counter 0, all *_valid=0, ready_out=0, pkt_out='0.
  - First cycle after rst=0: ready_out=1.
- Enqueue: valid_in && ready_out at a rising edge writes the tail.
  - ready_out = (count != DEPTH), from registered count only.
  - A simultaneous dequeue does not raise ready_out in the same cycle.
- Latency: a packet enqueued at edge N appears at pkt_out with its valid asserted in cycle N+1 at the earliest. There is no bypass.
- Steering: exactly one of alu/lsu/bru_valid is high when the FIFO is non-empty and the head is eligible.
  - FU_ALU goes to alu, FU_LSU to lsu, FU_BRU to bru.
  - Any other fu_type value goes to alu.
  - Head is eligible unless it is FU_BRU and br_inflight == MAX_BR.
  - Valids do not depend on the *_ready inputs.
- Dequeue: the selected valid && its ready pops the head. At most one pop per cycle; strictly in order.
  - A stalled head blocks all younger packets.
- Stability: once a valid is asserted, pkt_out and that valid hold until accepted or flushed.
- Branch counter:
  - +1 on a BRU pop; -1 on br_resolve.
  - Both in the same cycle: unchanged.
  - br_resolve at 0: ignored, no underflow.
- Flush (highest priority after rst):
  - Empties the FIFO, zeroes the counter and drops a valid_in arriving that cycle.
  - All *_valid are 0 in the flush cycle.
  - br_resolve and any pop in the flush cycle are ignored.
  - ready_out returns to 1 the next cycle.
- Pointer arithmetic: read/write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Packets with all-zero fields (unknown-opcode NOPs from decode) are dispatched to ALU like any other packet. They are not dropped.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- When defined:
  - Adds output stall_cycles, 32 bits.
  - Increments in every cycle where the FIFO is non-empty and no pop occurs (backpressure or branch throttle).
  - Saturates at 0xFFFFFFFF; cleared by rst only, not by flush.
- When undefined: the port and counter do not exist, with no other behaviour change.

Test Plan:
- Reset, then enqueue ALU pkt pc=0x100 at edge 1 with alu_ready=1 -> alu_valid=1 with pkt_out.pc=0x100 in cycle 2, popped at edge 2; ready_out stays 1.
- Hold all *_ready=0 and enqueue 4 pkts -> ready_out=0 after the 4th; a 5th valid_in is not accepted; release lsu_ready with an LSU head -> single pop, ready_out=1 the next cycle, order preserved.
- MAX_BR=4: dispatch 4 BRU pkts with no resolve -> br_inflight=4, 5th BRU head has bru_valid=0 and the ALU pkt behind it waits; pulse br_resolve -> bru_valid=1 the next cycle, br_inflight stays 4 after that pop.
- br_inflight=2 with br_resolve coincident with a BRU pop -> br_inflight stays 2; br_resolve at 0 -> stays 0.
- FIFO holds 3 pkts, br_inflight=3, assert flush with valid_in=1 -> next cycle count=0, all valids 0, br_inflight=0, and the incoming pkt never appears at pkt_out.
- DISPATCH_STATS_EN: head stalled 7 cycles by lsu_ready=0, then flush -> stall_cycles=7 and unchanged by flush.
